sram_bridge: RTL and testbench

- Wishbone slave that sits directly downstream of the write-back cache's master port and serves its single-word 32-bit fills and flushes from external asynchronous 16-bit SRAM.
- Each 32-bit access becomes two 16-bit SRAM cycles: low half first, then high half.
- SRAM strobe timing is set by parameterised wait states.
- One transaction is in flight at a time. s_ack_o is a single-cycle pulse.

---
 rtl/bexkat_mem_pkg.sv | 19 +
 rtl/sram_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_sram_bridge.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bexkat_mem_pkg.sv
// Shared definitions for the cache-side memory path.
//   state_e  : sram_bridge sequencer states
//   WADR_W   : Wishbone word-address width (32-bit words)
//   HALF_W   : external SRAM data width (16-bit halfwords)
package bexkat_mem_pkg;

    localparam int WADR_W = 25;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSETUP,
        WPULSE,
        WHOLD,
        ACK
    } state_e;

endpackage

// File: rtl/sram_bridge.sv
// Wishbone slave that serves single-word 32-bit cache fills and flushes
// from an asynchronous 16-bit SRAM. Each word is two SRAM cycles, low
// halfword first. Strobe widths are set by RD_WAIT / WR_WAIT (1..15).
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   s_cyc_i, s_stb_i    Wishbone request
//   s_we_i, s_sel_i     direction, byte lanes
//   s_adr_i, s_dat_i    word address, write data
//   s_dat_o, s_ack_o    read data, one-cycle acknowledge
//   sram_adr_o          halfword address {word, half}
//   sram_dq_o/_i/_oe_o  split bidirectional data pad
//   sram_*_n_o          active-low SRAM strobes (all registered)
module sram_bridge
    import bexkat_mem_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                s_cyc_i,
    input  logic                s_stb_i,
    input  logic                s_we_i,
    input  logic [WADR_W-1:0]   s_adr_i,
    input  logic [3:0]          s_sel_i,
    input  logic [31:0]         s_dat_i,
    output logic [31:0]         s_dat_o,
    output logic                s_ack_o,
    output logic [WADR_W:0]     sram_adr_o,
    output logic [HALF_W-1:0]   sram_dq_o,
    input  logic [HALF_W-1:0]   sram_dq_i,
    output logic                sram_dq_oe_o,
    output logic                sram_ce_n_o,
    output logic                sram_oe_n_o,
    output logic                sram_we_n_o,
    output logic                sram_ub_n_o,
    output logic                sram_lb_n_o
);

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

    state_e              state_q;
    logic                half_q;
    logic [3:0]          cnt_q;
    logic [WADR_W-1:0]   adr_q;
    logic [3:0]          sel_q;
    logic [31:0]         dat_q;
    logic [31:0]         rdat_q;
    logic                ack_q;
    logic [WADR_W:0]     sram_adr_q;
    logic [HALF_W-1:0]   dq_q;
    logic                dq_oe_q;
    logic                ce_n_q;
    logic                oe_n_q;
    logic                we_n_q;
    logic                ub_n_q;
    logic                lb_n_q;

    // NOTE: every pad-facing output is set on the edge that enters the
    // state it belongs to, so strobes come straight from flops and never
    // glitch; state and outputs therefore live in one always_ff with <=.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            half_q     <= 1'b0;
            cnt_q      <= '0;
            adr_q      <= '0;
            sel_q      <= '0;
            dat_q      <= '0;
            rdat_q     <= '0;
            ack_q      <= 1'b0;
            sram_adr_q <= '0;
            dq_q       <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_cyc_i && s_stb_i) begin
                        adr_q <= s_adr_i;
                        sel_q <= s_sel_i;
                        dat_q <= s_dat_i;
                        if (!s_we_i) begin
                            // Reads always fetch both bytes of each halfword.
                            state_q    <= RD;
                            half_q     <= 1'b0;
                            cnt_q      <= RD_LOAD;
                            sram_adr_q <= {s_adr_i, 1'b0};
                            ce_n_q     <= 1'b0;
                            oe_n_q     <= 1'b0;
                            ub_n_q     <= 1'b0;
                            lb_n_q     <= 1'b0;
                            dq_oe_q    <= 1'b0;
                        end else if (s_sel_i[1:0] != 2'b00) begin
                            state_q    <= WSETUP;
                            half_q     <= 1'b0;
                            sram_adr_q <= {s_adr_i, 1'b0};
                            dq_q       <= s_dat_i[15:0];
                            ub_n_q     <= ~s_sel_i[1];
                            lb_n_q     <= ~s_sel_i[0];
                            ce_n_q     <= 1'b0;
                            dq_oe_q    <= 1'b1;
                        end else if (s_sel_i[3:2] != 2'b00) begin
                            // Low half has no enabled bytes: skip its cycle.
                            state_q    <= WSETUP;
                            half_q     <= 1'b1;
                            sram_adr_q <= {s_adr_i, 1'b1};
                            dq_q       <= s_dat_i[31:16];
                            ub_n_q     <= ~s_sel_i[3];
                            lb_n_q     <= ~s_sel_i[2];
                            ce_n_q     <= 1'b0;
                            dq_oe_q    <= 1'b1;
                        end else begin
                            state_q <= ACK;
                            ack_q   <= 1'b1;
                        end
                    end
                end

                RD: begin
                    if (cnt_q == 4'd0) begin
                        // Last OE_n cycle: the pad data is settled now.
                        if (!half_q) begin
                            rdat_q[15:0] <= sram_dq_i;
                            half_q       <= 1'b1;
                            cnt_q        <= RD_LOAD;
                            sram_adr_q   <= {adr_q, 1'b1};
                        end else begin
                            rdat_q[31:16] <= sram_dq_i;
                            state_q       <= ACK;
                            ack_q         <= 1'b1;
                            ce_n_q        <= 1'b1;
                            oe_n_q        <= 1'b1;
                            ub_n_q        <= 1'b1;
                            lb_n_q        <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                WSETUP: begin
                    state_q <= WPULSE;
                    cnt_q   <= WR_LOAD;
                    we_n_q  <= 1'b0;
                end

                WPULSE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= WHOLD;
                        we_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                WHOLD: begin
                    if (!half_q && (sel_q[3:2] != 2'b00)) begin
                        state_q    <= WSETUP;
                        half_q     <= 1'b1;
                        sram_adr_q <= {adr_q, 1'b1};
                        dq_q       <= dat_q[31:16];
                        ub_n_q     <= ~sel_q[3];
                        lb_n_q     <= ~sel_q[2];
                    end else begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                        ce_n_q  <= 1'b1;
                        ub_n_q  <= 1'b1;
                        lb_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                    end
                end

                ACK: begin
                    // No capture here; the next request is seen from IDLE.
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_dat_o      = rdat_q;
    assign s_ack_o      = ack_q;
    assign sram_adr_o   = sram_adr_q;
    assign sram_dq_o    = dq_q;
    assign sram_dq_oe_o = dq_oe_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_ub_n_o  = ub_n_q;
    assign sram_lb_n_o  = lb_n_q;

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge with RD_WAIT = WR_WAIT = 2. A small SRAM
// model applies byte-lane writes while WE_n is low, returns read data while
// OE_n is low, and counts strobe activity so each step can compare deltas.
module tb_sram_bridge;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;

    logic        clk;
    logic        rst_n;
    logic        s_cyc, s_stb, s_we;
    logic [24:0] s_adr;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_w;
    logic [31:0] s_dat_r;
    logic        s_ack;
    logic [25:0] sram_adr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    sram_bridge #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .s_cyc_i      (s_cyc),
        .s_stb_i      (s_stb),
        .s_we_i       (s_we),
        .s_adr_i      (s_adr),
        .s_sel_i      (s_sel),
        .s_dat_i      (s_dat_w),
        .s_dat_o      (s_dat_r),
        .s_ack_o      (s_ack),
        .sram_adr_o   (sram_adr),
        .sram_dq_o    (sram_dq_out),
        .sram_dq_i    (sram_dq_in),
        .sram_dq_oe_o (sram_dq_oe),
        .sram_ce_n_o  (sram_ce_n),
        .sram_oe_n_o  (sram_oe_n),
        .sram_we_n_o  (sram_we_n),
        .sram_ub_n_o  (sram_ub_n),
        .sram_lb_n_o  (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- SRAM model ----------------
    logic [15:0] mem [logic [25:0]];

    function automatic logic [15:0] preload(input logic [25:0] a);
        case (a)
            26'h20:  return 16'h1234;
            26'h21:  return 16'hABCD;
            26'h40:  return 16'h1111;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] rd(input logic [25:0] a);
        if (mem.exists(a)) return mem[a];
        return preload(a);
    endfunction

    int   ce_cyc = 0, oe_cyc = 0, we_cyc = 0, we_pulses = 0;
    int   dqoe_cyc = 0, bad_dq = 0, ack_cyc = 0;
    logic prev_we_n = 1'b1;
    logic last_ub = 1'b1, last_lb = 1'b1;

    initial sram_dq_in = 16'h0000;

    always @(negedge clk) begin
        logic [15:0] w;
        if (!sram_ce_n) ce_cyc++;
        if (!sram_oe_n) oe_cyc++;
        if (sram_dq_oe) dqoe_cyc++;
        if (sram_dq_oe && (!sram_oe_n || s_ack || sram_ce_n)) bad_dq++;
        if (s_ack) ack_cyc++;
        if (!sram_we_n && !sram_ce_n) begin
            we_cyc++;
            last_ub = sram_ub_n;
            last_lb = sram_lb_n;
            w = rd(sram_adr);
            if (!sram_ub_n) w[15:8] = sram_dq_out[15:8];
            if (!sram_lb_n) w[7:0]  = sram_dq_out[7:0];
            mem[sram_adr] = w;
        end
        if (!prev_we_n && sram_we_n) we_pulses++;
        prev_we_n = sram_we_n;
        sram_dq_in = (!sram_oe_n && !sram_ce_n) ? rd(sram_adr) : 16'h0000;
    end

    // One request from an IDLE cycle; lat = negedges from capture edge to ack.
    task automatic do_req(input logic we, input logic [24:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input bit hold, output int lat);
        @(negedge clk);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = adr; s_sel = sel; s_dat_w = dat;
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            s_cyc = 1'b0; s_stb = 1'b0;
        end
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            if (s_ack) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, lat2, snap_a, snap_b, snap_c;
        bit found;

        rst_n = 1'b0;
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        s_adr = '0; s_sel = '0; s_dat_w = '0;
        repeat (2) @(negedge clk);
        check("reset strobes {ce,oe,we,ub,lb}", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check("reset dq_oe/ack", {sram_dq_oe, s_ack}, 2'b00);
        check("reset s_dat_o", s_dat_r, 32'h0);
        check("reset sram_adr", sram_adr, 26'h0);
        rst_n = 1'b1;

        // Reset in the middle of a write pulse.
        @(negedge clk);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 25'h15; s_sel = 4'hF; s_dat_w = 32'h9999_8888;
        @(posedge clk);
        @(negedge clk);
        s_cyc = 1'b0; s_stb = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!sram_we_n) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach WPULSE", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check("mid reset dq_oe/ack/adr", {sram_dq_oe, s_ack, sram_adr}, 28'h0);
        snap_a = ack_cyc;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no ack after reset", 32'(ack_cyc - snap_a), 32'd0);
        check("idle after reset ce_n", sram_ce_n, 1'b1);

        // Read word 0x10 -> halfwords 0x20/0x21.
        snap_a = oe_cyc; snap_b = dqoe_cyc;
        do_req(1'b0, 25'h10, 4'hF, 32'h0, 1'b0, lat);
        check("read latency", lat, 32'd5);
        check("read data", s_dat_r, 32'hABCD_1234);
        check("read oe_n low cycles", 32'(oe_cyc - snap_a), 32'd4);
        check("read dq_oe cycles", 32'(dqoe_cyc - snap_b), 32'd0);
        @(negedge clk);
        check("ack single cycle", s_ack, 1'b0);
        check("s_dat_o holds", s_dat_r, 32'hABCD_1234);

        // Full write at the top of the address space.
        snap_a = we_cyc; snap_b = we_pulses;
        do_req(1'b1, 25'h1FF_FFFF, 4'hF, 32'hDEAD_BEEF, 1'b0, lat);
        check("full write latency", lat, 32'd9);
        check("full write we_n low cycles", 32'(we_cyc - snap_a), 32'd4);
        check("full write pulses", 32'(we_pulses - snap_b), 32'd2);
        check("full write low half", rd(26'h3FF_FFFE), 16'hBEEF);
        check("full write high half", rd(26'h3FF_FFFF), 16'hDEAD);
        check("s_dat_o holds over write", s_dat_r, 32'hABCD_1234);

        // High half only.
        snap_a = we_cyc;
        do_req(1'b1, 25'h30, 4'hC, 32'h5566_7788, 1'b0, lat);
        check("selC latency", lat, 32'd5);
        check("selC we_n low cycles", 32'(we_cyc - snap_a), 32'd2);
        check("selC high half", rd(26'h61), 16'h5566);
        check("selC low half untouched", 32'(mem.exists(26'h60)), 32'd0);
        check("selC ub/lb", {last_ub, last_lb}, 2'b00);

        // Upper byte of low half only.
        do_req(1'b1, 25'h20, 4'h2, 32'h0000_AA55, 1'b0, lat);
        check("sel2 latency", lat, 32'd5);
        check("sel2 merged halfword", rd(26'h40), 16'hAA11);
        check("sel2 ub/lb", {last_ub, last_lb}, 2'b01);
        check("sel2 high half untouched", 32'(mem.exists(26'h41)), 32'd0);

        // No byte lanes: ack without any SRAM cycle.
        snap_c = ce_cyc;
        do_req(1'b1, 25'h44, 4'h0, 32'hFFFF_FFFF, 1'b0, lat);
        check("sel0 latency", lat, 32'd1);
        check("sel0 no ce_n activity", 32'(ce_cyc - snap_c), 32'd0);

        // Back-to-back read then write with cyc/stb held high.
        do_req(1'b0, 25'h10, 4'hF, 32'h0, 1'b1, lat);
        check("b2b read latency", lat, 32'd5);
        check("b2b read data", s_dat_r, 32'hABCD_1234);
        s_we = 1'b1; s_adr = 25'h08; s_sel = 4'hF; s_dat_w = 32'h0BAD_F00D;
        lat2 = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (s_ack) begin
                lat2 = i;
                break;
            end
        end
        s_cyc = 1'b0; s_stb = 1'b0;
        check("b2b ack-to-ack spacing", lat2, 32'd10);
        check("b2b write low half", rd(26'h10), 16'hF00D);
        check("b2b write high half", rd(26'h11), 16'h0BAD);
        repeat (3) @(negedge clk);
        check("dq_oe only in write states", bad_dq, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
